// File: rtl/fd_ex_stage_ctrl.sv
// FD/EX pipeline register with load-use stall resolution, operand forwarding
// and taken-branch flush. Also keeps saturating counts of stalls and flushes.
module fd_ex_stage_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fd_valid,
    input  logic [XLEN-1:0]  fd_pc,
    input  logic [31:0]      fd_inst,
    input  logic [4:0]       fd_rs1,
    input  logic [4:0]       fd_rs2,
    input  logic [4:0]       fd_rd,
    input  logic             fd_reg_wrenable,
    input  logic             fd_mem_to_reg,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,
    input  logic             fwd_a,
    input  logic             fwd_b,
    input  logic             should_stall,
    input  logic [XLEN-1:0]  ex_fwd_data,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             ex_branch_taken,
    output logic             pc_wrenable,
    output logic             fd_wrenable,
    output logic             fd_flush,
    output logic             ex_valid,
    output logic             ex_reg_wrenable,
    output logic             ex_mem_to_reg,
    output logic [XLEN-1:0]  ex_pc,
    output logic [31:0]      ex_inst,
    output logic [4:0]       ex_rd,
    output logic [XLEN-1:0]  ex_rs1_val,
    output logic [XLEN-1:0]  ex_rs2_val,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        RUN     = 1'b0,
        RESOLVE = 1'b1
    } state_t;

    // What the EX register does at the next edge.
    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_STALL = 2'd1,
        ACT_FLUSH = 2'd2
    } action_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t          state;
    state_t          state_next;
    action_t         action;
    logic            match_a;
    logic            match_b;
    logic [XLEN-1:0] rs1_sel;
    logic [XLEN-1:0] rs2_sel;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        action      = ACT_LOAD;
        state_next  = RUN;
        pc_wrenable = 1'b1;
        fd_wrenable = 1'b1;
        fd_flush    = 1'b0;
        if (!rst) begin
            if (ex_branch_taken) begin
                action   = ACT_FLUSH;
                fd_flush = 1'b1;
            end else if (state == RUN && should_stall) begin
                action      = ACT_STALL;
                state_next  = RESOLVE;
                pc_wrenable = 1'b0;
                fd_wrenable = 1'b0;
            end
        end
    end

    // In RESOLVE the load result is in writeback, so a recorded match overrides forwarding.
    always_comb begin
        rs1_sel = fwd_a ? ex_fwd_data : rf_rs1_data;
        rs2_sel = fwd_b ? ex_fwd_data : rf_rs2_data;
        if (state == RESOLVE && match_a) rs1_sel = wb_data;
        if (state == RESOLVE && match_b) rs2_sel = wb_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_a <= 1'b0;
            match_b <= 1'b0;
        end else if (action == ACT_STALL) begin
            match_a <= (ex_rd == fd_rs1);
            match_b <= (ex_rd == fd_rs2);
        end else begin
            match_a <= 1'b0;
            match_b <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid        <= 1'b0;
            ex_reg_wrenable <= 1'b0;
            ex_mem_to_reg   <= 1'b0;
            ex_pc           <= '0;
            ex_inst         <= '0;
            ex_rd           <= '0;
            ex_rs1_val      <= '0;
            ex_rs2_val      <= '0;
        end else if (action == ACT_LOAD) begin
            ex_valid        <= fd_valid;
            ex_reg_wrenable <= fd_reg_wrenable & fd_valid;
            ex_mem_to_reg   <= fd_mem_to_reg & fd_valid;
            ex_pc           <= fd_pc;
            ex_inst         <= fd_inst;
            ex_rd           <= fd_rd;
            ex_rs1_val      <= rs1_sel;
            ex_rs2_val      <= rs2_sel;
        end else begin
            // Bubble: only the control bits drop, the payload fields are left as they were.
            ex_valid        <= 1'b0;
            ex_reg_wrenable <= 1'b0;
            ex_mem_to_reg   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (action == ACT_STALL && stall_count != CNT_MAX)
                stall_count <= stall_count + CNT_W'(1);
            if (action == ACT_FLUSH && flush_count != CNT_MAX)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fd_ex_stage_ctrl.sv
// Bench for fd_ex_stage_ctrl: directed vector table, hand-written corner
// sequences, then random stimulus against a behavioural reference model.
module tb_fd_ex_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fd_valid;
    logic [31:0] fd_pc, fd_inst;
    logic [4:0]  fd_rs1, fd_rs2, fd_rd;
    logic        fd_reg_wrenable, fd_mem_to_reg;
    logic [31:0] rf_rs1_data, rf_rs2_data, ex_fwd_data, wb_data;
    logic        fwd_a, fwd_b, should_stall, ex_branch_taken;

    logic        pc_wrenable, fd_wrenable, fd_flush;
    logic        ex_valid, ex_reg_wrenable, ex_mem_to_reg;
    logic [31:0] ex_pc, ex_inst, ex_rs1_val, ex_rs2_val;
    logic [4:0]  ex_rd;
    logic [15:0] stall_count, flush_count;

    logic        s_pc_we, s_fd_we, s_flush, s_valid, s_rw, s_mr;
    logic [31:0] s_pc, s_inst, s_rs1, s_rs2;
    logic [4:0]  s_rd;
    logic [1:0]  s_stall_count, s_flush_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fd_ex_stage_ctrl #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .fd_valid(fd_valid), .fd_pc(fd_pc), .fd_inst(fd_inst),
        .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_rd(fd_rd),
        .fd_reg_wrenable(fd_reg_wrenable), .fd_mem_to_reg(fd_mem_to_reg),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .should_stall(should_stall),
        .ex_fwd_data(ex_fwd_data), .wb_data(wb_data), .ex_branch_taken(ex_branch_taken),
        .pc_wrenable(pc_wrenable), .fd_wrenable(fd_wrenable), .fd_flush(fd_flush),
        .ex_valid(ex_valid), .ex_reg_wrenable(ex_reg_wrenable), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_rd(ex_rd),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    fd_ex_stage_ctrl #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .fd_valid(fd_valid), .fd_pc(fd_pc), .fd_inst(fd_inst),
        .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_rd(fd_rd),
        .fd_reg_wrenable(fd_reg_wrenable), .fd_mem_to_reg(fd_mem_to_reg),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .should_stall(should_stall),
        .ex_fwd_data(ex_fwd_data), .wb_data(wb_data), .ex_branch_taken(ex_branch_taken),
        .pc_wrenable(s_pc_we), .fd_wrenable(s_fd_we), .fd_flush(s_flush),
        .ex_valid(s_valid), .ex_reg_wrenable(s_rw), .ex_mem_to_reg(s_mr),
        .ex_pc(s_pc), .ex_inst(s_inst), .ex_rd(s_rd),
        .ex_rs1_val(s_rs1), .ex_rs2_val(s_rs2),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int sat(input int n, input int max);
        return (n > max) ? max : n;
    endfunction

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        fa, fb, stall, branch;
        logic [31:0] rf1, rf2, exf, wb;
        logic        e_pc_we, e_flush;
        logic        e_valid;
        logic [31:0] e_pc, e_rs1, e_rs2;
        int          e_sc, e_fc;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(
        input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
        input logic fa, fb, st, br, input logic [31:0] rf1, rf2, exf, wb,
        input logic e_pc_we, e_flush, e_valid, input logic [31:0] e_pc, e_rs1, e_rs2,
        input int e_sc, e_fc);
        vec_t r;
        r.valid = v; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.fa = fa; r.fb = fb; r.stall = st; r.branch = br;
        r.rf1 = rf1; r.rf2 = rf2; r.exf = exf; r.wb = wb;
        r.e_pc_we = e_pc_we; r.e_flush = e_flush; r.e_valid = e_valid;
        r.e_pc = e_pc; r.e_rs1 = e_rs1; r.e_rs2 = e_rs2; r.e_sc = e_sc; r.e_fc = e_fc;
        return r;
    endfunction

    task automatic idle_inputs();
        fd_valid = 1'b0; fd_pc = '0; fd_inst = '0; fd_rs1 = '0; fd_rs2 = '0; fd_rd = '0;
        fd_reg_wrenable = 1'b0; fd_mem_to_reg = 1'b0;
        rf_rs1_data = '0; rf_rs2_data = '0; ex_fwd_data = '0; wb_data = '0;
        fwd_a = 1'b0; fwd_b = 1'b0; should_stall = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        fd_valid = v.valid; fd_pc = v.pc; fd_inst = v.pc ^ 32'hDEAD_0000;
        fd_rs1 = v.rs1; fd_rs2 = v.rs2; fd_rd = v.rd;
        fd_reg_wrenable = 1'b1; fd_mem_to_reg = 1'b0;
        fwd_a = v.fa; fwd_b = v.fb; should_stall = v.stall; ex_branch_taken = v.branch;
        rf_rs1_data = v.rf1; rf_rs2_data = v.rf2; ex_fwd_data = v.exf; wb_data = v.wb;
        #1;
        check($sformatf("vec%0d pc_wrenable", idx), pc_wrenable, v.e_pc_we);
        check($sformatf("vec%0d fd_wrenable", idx), fd_wrenable, v.e_pc_we);
        check($sformatf("vec%0d fd_flush", idx), fd_flush, v.e_flush);
        @(posedge clk); #1;
        check($sformatf("vec%0d ex_valid", idx), ex_valid, v.e_valid);
        check($sformatf("vec%0d ex_pc", idx), ex_pc, v.e_pc);
        check($sformatf("vec%0d ex_rs1_val", idx), ex_rs1_val, v.e_rs1);
        check($sformatf("vec%0d ex_rs2_val", idx), ex_rs2_val, v.e_rs2);
        check($sformatf("vec%0d stall_count", idx), stall_count, 64'(v.e_sc));
        check($sformatf("vec%0d flush_count", idx), flush_count, 64'(v.e_fc));
        check($sformatf("vec%0d sat stall_count", idx), s_stall_count, 64'(sat(v.e_sc, 3)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ex_valid"}, ex_valid, 0);
        check({tag, " ex_reg_wrenable"}, ex_reg_wrenable, 0);
        check({tag, " ex_mem_to_reg"}, ex_mem_to_reg, 0);
        check({tag, " ex_pc"}, ex_pc, 0);
        check({tag, " ex_inst"}, ex_inst, 0);
        check({tag, " ex_rd"}, ex_rd, 0);
        check({tag, " ex_rs1_val"}, ex_rs1_val, 0);
        check({tag, " ex_rs2_val"}, ex_rs2_val, 0);
        check({tag, " stall_count"}, stall_count, 0);
        check({tag, " flush_count"}, flush_count, 0);
        check({tag, " pc_wrenable"}, pc_wrenable, 1);
        check({tag, " fd_wrenable"}, fd_wrenable, 1);
        check({tag, " fd_flush"}, fd_flush, 0);
    endtask

    // Reference model: the pipeline as a record plus a "stall pending" flag.
    bit          m_pending, m_ma, m_mb;
    bit          m_v, m_rw, m_mr;
    logic [31:0] m_pc, m_inst, m_rs1, m_rs2;
    logic [4:0]  m_rd;
    int          m_sc, m_fc;

    task automatic model_reset();
        m_pending = 0; m_ma = 0; m_mb = 0; m_v = 0; m_rw = 0; m_mr = 0;
        m_pc = '0; m_inst = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_sc = 0; m_fc = 0;
    endtask

    task automatic random_cycle(input int n);
        logic [31:0] op1, op2;
        bit held;
        fd_valid = ($urandom_range(0, 3) != 0);
        fd_pc = $urandom; fd_inst = $urandom;
        fd_rs1 = 5'($urandom_range(0, 3)); fd_rs2 = 5'($urandom_range(0, 3));
        fd_rd = 5'($urandom_range(0, 3));
        fd_reg_wrenable = $urandom_range(0, 1) != 0; fd_mem_to_reg = $urandom_range(0, 1) != 0;
        rf_rs1_data = $urandom; rf_rs2_data = $urandom; ex_fwd_data = $urandom; wb_data = $urandom;
        fwd_a = $urandom_range(0, 1) != 0; fwd_b = $urandom_range(0, 1) != 0;
        should_stall = ($urandom_range(0, 9) < 4);
        ex_branch_taken = ($urandom_range(0, 9) == 0);
        #1;
        held = !m_pending && should_stall && !ex_branch_taken;
        op1 = (m_pending && m_ma) ? wb_data : (fwd_a ? ex_fwd_data : rf_rs1_data);
        op2 = (m_pending && m_mb) ? wb_data : (fwd_b ? ex_fwd_data : rf_rs2_data);
        check($sformatf("rnd%0d pc_wrenable", n), pc_wrenable, !held);
        check($sformatf("rnd%0d fd_wrenable", n), fd_wrenable, !held);
        check($sformatf("rnd%0d fd_flush", n), fd_flush, ex_branch_taken);
        @(posedge clk);
        if (ex_branch_taken) begin
            m_v = 0; m_rw = 0; m_mr = 0; m_pending = 0; m_ma = 0; m_mb = 0; m_fc++;
        end else if (held) begin
            m_v = 0; m_rw = 0; m_mr = 0;
            m_ma = (m_rd == fd_rs1); m_mb = (m_rd == fd_rs2); m_pending = 1; m_sc++;
        end else begin
            m_v = fd_valid; m_rw = fd_reg_wrenable && fd_valid; m_mr = fd_mem_to_reg && fd_valid;
            m_pc = fd_pc; m_inst = fd_inst; m_rd = fd_rd; m_rs1 = op1; m_rs2 = op2;
            m_pending = 0; m_ma = 0; m_mb = 0;
        end
        #1;
        check($sformatf("rnd%0d ex_valid", n), ex_valid, m_v);
        check($sformatf("rnd%0d ex_reg_wrenable", n), ex_reg_wrenable, m_rw);
        check($sformatf("rnd%0d ex_mem_to_reg", n), ex_mem_to_reg, m_mr);
        check($sformatf("rnd%0d ex_pc", n), ex_pc, m_pc);
        check($sformatf("rnd%0d ex_inst", n), ex_inst, m_inst);
        check($sformatf("rnd%0d ex_rd", n), ex_rd, m_rd);
        check($sformatf("rnd%0d ex_rs1_val", n), ex_rs1_val, m_rs1);
        check($sformatf("rnd%0d ex_rs2_val", n), ex_rs2_val, m_rs2);
        check($sformatf("rnd%0d stall_count", n), stall_count, 64'(sat(m_sc, 65535)));
        check($sformatf("rnd%0d flush_count", n), flush_count, 64'(sat(m_fc, 65535)));
        check($sformatf("rnd%0d sat stall_count", n), s_stall_count, 64'(sat(m_sc, 3)));
        check($sformatf("rnd%0d sat flush_count", n), s_flush_count, 64'(sat(m_fc, 3)));
    endtask

    initial begin
        //            v  pc        rs1 rs2 rd fa fb st br rf1    rf2    exf    wb       pcwe fl ev  ex_pc     rs1    rs2   sc fc
        tbl[0]  = mk(1, 32'h100, 1, 2, 4, 0, 0, 0, 0, 32'd5, 32'd7, 32'h0,  32'h0,   1, 0, 1, 32'h100, 32'd5,  32'd7,  0, 0);
        tbl[1]  = mk(1, 32'h104, 3, 5, 6, 1, 0, 0, 0, 32'd9, 32'd3, 32'hAA, 32'h0,   1, 0, 1, 32'h104, 32'hAA, 32'd3,  0, 0);
        tbl[2]  = mk(1, 32'h108, 1, 2, 4, 0, 0, 0, 0, 32'd1, 32'd2, 32'h0,  32'h0,   1, 0, 1, 32'h108, 32'd1,  32'd2,  0, 0);
        tbl[3]  = mk(1, 32'h10C, 7, 4, 8, 0, 0, 1, 0, 32'd11, 32'd12, 32'h0, 32'h55, 0, 0, 0, 32'h108, 32'd1,  32'd2,  1, 0);
        tbl[4]  = mk(1, 32'h10C, 7, 4, 8, 0, 0, 1, 0, 32'd11, 32'd12, 32'h0, 32'h55, 1, 0, 1, 32'h10C, 32'd11, 32'h55, 1, 0);
        tbl[5]  = mk(1, 32'h110, 1, 2, 3, 0, 0, 1, 1, 32'd1, 32'd2, 32'h0,  32'h0,   1, 1, 0, 32'h10C, 32'd11, 32'h55, 1, 1);
        tbl[6]  = mk(1, 32'h114, 8, 0, 9, 0, 0, 1, 0, 32'd1, 32'd2, 32'h0,  32'h66,  0, 0, 0, 32'h10C, 32'd11, 32'h55, 2, 1);
        tbl[7]  = mk(1, 32'h114, 8, 0, 9, 0, 1, 1, 0, 32'd1, 32'd2, 32'h77, 32'h66,  1, 0, 1, 32'h114, 32'h66, 32'h77, 2, 1);
        tbl[8]  = mk(1, 32'h118, 9, 9, 3, 0, 0, 1, 0, 32'd3, 32'd4, 32'h0,  32'h0,   0, 0, 0, 32'h114, 32'h66, 32'h77, 3, 1);
        tbl[9]  = mk(1, 32'h118, 9, 9, 3, 0, 0, 0, 1, 32'd3, 32'd4, 32'h0,  32'hEE,  1, 1, 0, 32'h114, 32'h66, 32'h77, 3, 2);
        tbl[10] = mk(1, 32'h11C, 1, 2, 5, 0, 0, 1, 0, 32'd3, 32'd4, 32'h0,  32'h0,   0, 0, 0, 32'h114, 32'h66, 32'h77, 4, 2);
        tbl[11] = mk(0, 32'h11C, 1, 2, 5, 0, 0, 0, 0, 32'd3, 32'd4, 32'h0,  32'h99,  1, 0, 0, 32'h11C, 32'd3,  32'd4,  4, 2);

        idle_inputs();
        rst = 1'b1;
        should_stall = 1'b1;
        ex_branch_taken = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) apply_vec(tbl[i], i);

        // Two more stall/resolve pairs: 6 stalls total, narrow counter pinned at 3.
        for (int k = 0; k < 2; k++) begin
            should_stall = 1'b1; fd_valid = 1'b1; ex_branch_taken = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        check("sat wide stall_count", stall_count, 6);
        check("sat narrow stall_count", s_stall_count, 3);
        check("sat narrow flush_count", s_flush_count, 2);

        // Reset asserted while in RESOLVE.
        should_stall = 1'b1;
        @(posedge clk); #1;
        check("pre-reset stalled", pc_wrenable, 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid-stall reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after reset in RUN stall honoured", pc_wrenable, 0);
        should_stall = 1'b0;

        // Random phase, model synchronised by a fresh reset.
        rst = 1'b1;
        #2;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < 400; n++) random_cycle(n);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fd_ex_stage_ctrl.md
# fd_ex_stage_ctrl

Decode-to-execute pipeline control and the FD/EX pipeline register. Acts on the forwarding and load-use stall requests from the hazard unit. Each cycle it selects forwarded operands, latches the decoded instruction into EX, holds PC and FD while a load-use stall is resolved, and flushes on a taken branch. It sits between the decode stage/register file and the EX stage, and its EX-side outputs feed back into the hazard unit.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, width of the stall and flush event counters

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- fd_valid  in  1  FD holds a real instruction
- fd_pc  in  XLEN  PC of FD instruction
- fd_inst  in  32  FD instruction word
- fd_rs1, fd_rs2, fd_rd  in  5 each  decoded register indices
- fd_reg_wrenable, fd_mem_to_reg  in  1 each  decoded control bits
- rf_rs1_data, rf_rs2_data  in  XLEN  register-file read data
- fwd_a, fwd_b, should_stall  in  1 each  hazard-unit requests
- ex_fwd_data  in  XLEN  current EX result, used for fwd_a/fwd_b
- wb_data  in  XLEN  load result arriving in writeback, used after a stall
- ex_branch_taken  in  1  EX resolved a taken branch
- pc_wrenable  out  1  PC may advance
- fd_wrenable  out  1  FD register may load
- fd_flush  out  1  FD register clears to bubble
- ex_valid, ex_reg_wrenable, ex_mem_to_reg  out  1 each  EX control
- ex_pc  out  XLEN;  ex_inst  out  32;  ex_rd  out  5
- ex_rs1_val, ex_rs2_val  out  XLEN  selected operands
- stall_count, flush_count  out  CNT_W  saturating event counters

## Operation
- States: RUN and RESOLVE. Reset puts the block in RUN.
- Operand select in RUN, per operand:
  - fwd_x=1 selects ex_fwd_data.
  - Otherwise the rf value is used.
- Operand select in RESOLVE, per operand:
  - The operand's recorded match bit selects wb_data.
  - Otherwise fwd_x applies, then rf.
- Priority each cycle, highest first:
  1. rst
  2. ex_branch_taken
  3. should_stall (RUN only)
  4. normal advance
- Branch flush (ex_branch_taken=1, either state):
  - EX loads a bubble: ex_valid, ex_reg_wrenable and ex_mem_to_reg all 0; other EX fields keep their previous values.
  - fd_flush=1; pc_wrenable=1; fd_wrenable=1.
  - Next state is RUN and recorded match bits clear.
  - flush_count increments. stall_count does not change, even if should_stall=1.
- Load-use stall (RUN, should_stall=1, no branch):
  - EX loads a bubble; pc_wrenable=0; fd_wrenable=0; fd_flush=0.
  - Record match_a=(ex_rd==fd_rs1) and match_b=(ex_rd==fd_rs2), with ex_rd taken from the current EX register.
  - Next state is RESOLVE; stall_count increments.
- RESOLVE, no branch:
  - The held FD instruction latches into EX with the substituted operands. pc_wrenable=1, fd_wrenable=1.
  - Next state is RUN. should_stall is ignored in this state, because EX holds a bubble.
- Normal advance (RUN):
  - EX loads all fd_* fields and the selected operands.
  - ex_valid equals fd_valid. ex_reg_wrenable and ex_mem_to_reg are ANDed with fd_valid.
  - pc_wrenable=1; fd_wrenable=1.
- Counters:
  - Unsigned; each increments by 1 per event.
  - A counter holds at 2^CNT_W-1 and never wraps.

## Timing
- Reset values:
  - ex_valid=0, ex_reg_wrenable=0, ex_mem_to_reg=0.
  - ex_pc=0, ex_inst=0, ex_rd=0, ex_rs1_val=0, ex_rs2_val=0.
  - stall_count=0, flush_count=0; state RUN; match bits 0.
- Combinational outputs follow state and inputs. While rst=1: pc_wrenable=1, fd_wrenable=1, fd_flush=0.
- FD-to-EX latency is 1 cycle. A load-use stall adds exactly 1 cycle.
- Operand select is combinational and is captured at the rising edge.
- Reset asserted in RESOLVE returns the block to RUN immediately. The stalled instruction is not replayed by this block.
- Back-to-back stalls: RESOLVE always returns to RUN first. A second should_stall is honoured one cycle after RESOLVE.

## Test plan
- Normal advance:
  - Stimulus: fd_valid=1, fd_pc=0x100, rf_rs1_data=5, rf_rs2_data=7, no fwd.
  - Response: next cycle ex_pc=0x100, ex_rs1_val=5, ex_rs2_val=7, ex_valid=1.
- Forwarding:
  - Stimulus: fwd_a=1, fwd_b=0, ex_fwd_data=0xAA, rf_rs2_data=3.
  - Response: ex_rs1_val=0xAA, ex_rs2_val=3.
- Load-use stall:
  - Stimulus: ex_rd=4, fd_rs2=4, should_stall=1.
  - Response in the same cycle: pc_wrenable=0, fd_wrenable=0.
  - Response next cycle: ex_valid=0; stall_count=1.
  - Then, with wb_data=0x55, the following cycle gives ex_rs2_val=0x55 and ex_valid=1.
- Simultaneous branch and stall:
  - Stimulus: ex_branch_taken=1 and should_stall=1 together.
  - Response: fd_flush=1, pc_wrenable=1, ex_valid=0 next cycle, flush_count=1, stall_count=0.
- Counter saturation:
  - Stimulus: CNT_W=2, 5 stalls.
  - Response: stall_count reaches 3 and holds.
- Reset mid-stall:
  - Stimulus: assert rst in RESOLVE.
  - Response: all EX outputs 0 and counters 0 immediately; state is RUN.
